// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC ownership, req/ack fetch from instruction
// memory, single-entry output slot, redirect with stale-response flush, and
// a sticky timeout flag for a memory that never answers.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_VEC      = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic        fetch_err
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc_reg, pc_reg_nxt;
  logic            req_nxt;
  logic [31:0]     addr_nxt;
  logic [31:0]     pc_out_nxt, inst_out_nxt;
  logic            valid_nxt, err_nxt, discard, discard_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            accept_c, slot_free_c;

  // Slot handshake with the IF/ID latch
  assign accept_c    = inst_valid && !stop;
  assign slot_free_c = !inst_valid || accept_c;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc_reg     <= RESET_VEC;
      imem_req   <= 1'b0;
      imem_addr  <= 32'h0;
      pc_out     <= 32'h0;
      inst_out   <= 32'h0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      discard    <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      pc_reg     <= pc_reg_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      pc_out     <= pc_out_nxt;
      inst_out   <= inst_out_nxt;
      inst_valid <= valid_nxt;
      fetch_err  <= err_nxt;
      discard    <= discard_nxt;
      timer      <= timer_nxt;
    end
  end

  // Next-state and next-output logic; redirect overrides slot and PC last
  always_comb begin
    state_nxt    = state;
    pc_reg_nxt   = pc_reg;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    pc_out_nxt   = pc_out;
    inst_out_nxt = inst_out;
    valid_nxt    = inst_valid;
    err_nxt      = fetch_err;
    discard_nxt  = discard;
    timer_nxt    = timer;

    if (accept_c) valid_nxt = 1'b0;

    case (state)
      S_REQ: begin
        // A redirect in this cycle delays the request so the new PC is used
        if (!redirect && slot_free_c) begin
          req_nxt   = 1'b1;
          addr_nxt  = pc_reg;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          timer_nxt   = '0;
          req_nxt     = 1'b0;
          discard_nxt = 1'b0;
          state_nxt   = S_REQ;
          if (!(discard || redirect)) begin
            pc_out_nxt   = pc_reg;
            inst_out_nxt = imem_rdata;
            valid_nxt    = 1'b1;
            pc_reg_nxt   = pc_reg + 32'd4;
          end
        end else begin
          if (timer < TMO_MAX) timer_nxt = timer + TW'(1);
          if (timer >= TMO_LAST) err_nxt = 1'b1;
          if (redirect) discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    if (redirect) begin
      pc_reg_nxt   = {redirect_pc[31:2], 2'b00};
      valid_nxt    = 1'b0;
      inst_out_nxt = 32'h0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural latency-L memory.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stop, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out, inst_out;
  logic        inst_valid, fetch_err;

  // Memory model controls
  logic        mem_on;
  int          mem_lat;
  logic        mdl_ack, man_ack;
  logic [31:0] mdl_rdata, man_rdata;
  int          cnt;

  int vectors = 0;
  int miscompares = 0;

  assign imem_ack   = mem_on ? mdl_ack   : man_ack;
  assign imem_rdata = mem_on ? mdl_rdata : man_rdata;

  inst_fetch_unit #(.RESET_VEC(32'h0040_0000), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .stop(stop), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .inst_out(inst_out), .inst_valid(inst_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory answers mem_lat negedges after the request becomes visible
  always @(negedge clk) begin
    if (rst || !mem_on) begin
      mdl_ack = 1'b0;
      cnt = 0;
    end else if (mdl_ack) begin
      mdl_ack = 1'b0;
    end else if (imem_req) begin
      cnt++;
      if (cnt >= mem_lat) begin
        mdl_ack   = 1'b1;
        mdl_rdata = word(imem_addr);
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    man_ack = 1'b0; man_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 30) begin tick(); n++; end
    vectors++;
    if (!imem_req) begin
      miscompares++;
      $display("FAIL %s: imem_req never rose (got %0b, want 1)", name, imem_req);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 30) begin tick(); n++; end
    vectors++;
    if (!inst_valid) begin
      miscompares++;
      $display("FAIL %s: inst_valid never rose (got %0b, want 1)", name, inst_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    man_ack = 1'b0; man_rdata = 32'h0; mem_on = 1'b1; mem_lat = 1;
    tick();
    vectors++;
    if ({imem_req, imem_addr, pc_out, inst_out, inst_valid, fetch_err} !== 99'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%0b addr=%h pc=%h inst=%h v=%0b err=%0b want all 0",
               imem_req, imem_addr, pc_out, inst_out, inst_valid, fetch_err);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      miscompares++;
      $display("FAIL reset_first_req: got req=%0b addr=%h want 1 00400000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] a;
    mem_on = 1'b1; mem_lat = 1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = 32'h0040_0000 + 32'(4 * k);
      wait_req("seq_req");
      vectors++;
      if (imem_addr !== a) begin
        miscompares++;
        $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, a);
      end
      if (k > 0) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL seq_valid_pulse%0d: got %0b want 0", k, inst_valid);
        end
      end
      wait_valid("seq_valid");
      vectors++;
      if (pc_out !== a || inst_out !== word(a)) begin
        miscompares++;
        $display("FAIL seq_slot%0d: got pc=%h inst=%h want pc=%h inst=%h",
                 k, pc_out, inst_out, a, word(a));
      end
    end
  endtask

  task automatic test_stall();
    mem_on = 1'b1; mem_lat = 1;
    do_reset();
    wait_req("stall_req0");
    wait_valid("stall_valid0");
    wait_req("stall_req1");
    stop = 1'b1;
    wait_valid("stall_valid1");
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h0040_0004 || inst_out !== word(32'h0040_0004) ||
          inst_valid !== 1'b1 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got pc=%h inst=%h v=%0b req=%0b want %h %h 1 0",
                 i, pc_out, inst_out, inst_valid, imem_req, 32'h0040_0004, word(32'h0040_0004));
      end
    end
    stop = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: got req=%0b addr=%h v=%0b want 1 00400008 0",
               imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    logic saw_valid;
    logic found;
    mem_on = 1'b1; mem_lat = 4;
    do_reset();
    wait_req("rdw_req");
    redirect = 1'b1; redirect_pc = 32'h0040_0103;
    tick();
    redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      miscompares++;
      $display("FAIL rdw_hold_addr: got req=%0b addr=%h want 1 00400000", imem_req, imem_addr);
    end
    saw_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (inst_valid) saw_valid = 1'b1;
      if (imem_req && imem_addr === 32'h0040_0100) found = 1'b1;
    end
    vectors++;
    if (!found || saw_valid) begin
      miscompares++;
      $display("FAIL rdw_flush: got found=%0b saw_valid=%0b want 1 0", found, saw_valid);
    end
    wait_valid("rdw_valid");
    vectors++;
    if (pc_out !== 32'h0040_0100 || inst_out !== word(32'h0040_0100)) begin
      miscompares++;
      $display("FAIL rdw_target: got pc=%h inst=%h want 00400100 %h",
               pc_out, inst_out, word(32'h0040_0100));
    end
  endtask

  task automatic test_redirect_ack();
    mem_on = 1'b1; mem_lat = 1;
    do_reset();
    wait_req("rda_req");
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    tick();
    redirect = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rda_drop: got v=%0b req=%0b want 0 0", inst_valid, imem_req);
    end
    wait_req("rda_req2");
    vectors++;
    if (imem_addr !== 32'h0040_0200) begin
      miscompares++;
      $display("FAIL rda_addr: got %h want 00400200", imem_addr);
    end
    wait_valid("rda_valid");
    vectors++;
    if (pc_out !== 32'h0040_0200 || inst_out !== word(32'h0040_0200)) begin
      miscompares++;
      $display("FAIL rda_target: got pc=%h inst=%h want 00400200 %h",
               pc_out, inst_out, word(32'h0040_0200));
    end
  endtask

  task automatic test_timeout();
    mem_on = 1'b0;
    do_reset();
    wait_req("tmo_req");
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_early: got %0b want 0", fetch_err);
    end
    tick();
    vectors++;
    if (fetch_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_set: got %0b want 1", fetch_err);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_sticky: got err=%0b req=%0b want 1 1", fetch_err, imem_req);
    end
    do_reset();
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_clear: got %0b want 0", fetch_err);
    end
  endtask

  task automatic test_wrap_and_reset();
    mem_on = 1'b1; mem_lat = 1;
    do_reset();
    wait_req("wrap_req0");
    wait_valid("wrap_valid0");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_redirect_req: got v=%0b req=%0b want 0 0", inst_valid, imem_req);
    end
    wait_req("wrap_req1");
    vectors++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_addr_top: got %h want fffffffc", imem_addr);
    end
    wait_valid("wrap_valid1");
    vectors++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_pc_top: got %h want fffffffc", pc_out);
    end
    wait_req("wrap_req2");
    vectors++;
    if (imem_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_addr_zero: got %h want 00000000", imem_addr);
    end
    mem_on = 1'b0; man_ack = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if ({imem_req, imem_addr, pc_out, inst_out, inst_valid, fetch_err} !== 99'h0) begin
      miscompares++;
      $display("FAIL midwait_reset: got req=%0b addr=%h pc=%h inst=%h v=%0b err=%0b want all 0",
               imem_req, imem_addr, pc_out, inst_out, inst_valid, fetch_err);
    end
    rst = 1'b0;
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      miscompares++;
      $display("FAIL late_ack: got v=%0b req=%0b addr=%h want 0 1 00400000",
               inst_valid, imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_timeout();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
